// File: rtl/cr_kme_int_aggr.sv
// Interrupt aggregator: sticky per-source status with W1C/W1S/mask/config registers,
// plus an event-count / timeout coalescing FSM driving a registered aggregate interrupt.
module cr_kme_int_aggr #(
  parameter int               N_SRC     = 5,
  parameter logic [N_SRC-1:0] EDGE_SEL  = '0,
  parameter int               THR_W     = 4,
  parameter int               TMO_W     = 16,
  parameter logic [10:0]      BASE_ADDR = 11'h37C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src_trig,
  input  logic             ext_int,
  input  logic             wr_stb,
  input  logic             rd_stb,
  input  logic [10:0]      reg_addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  output logic             rd_ack,
  output logic [N_SRC-1:0] int_status,
  output logic [N_SRC-1:0] int_mask,
  output logic             int_out
);

  localparam logic [10:0]      A_STATUS = BASE_ADDR;
  localparam logic [10:0]      A_FORCE  = BASE_ADDR + 11'd1;
  localparam logic [10:0]      A_MASK   = BASE_ADDR + 11'd2;
  localparam logic [10:0]      A_CFG    = BASE_ADDR + 11'd3;
  localparam logic [THR_W-1:0] THR_ONE  = THR_W'(1);
  localparam logic [THR_W-1:0] CNT_MAX  = '1;
  localparam logic [TMO_W-1:0] TMR_ONE  = TMO_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COAL,
    S_ASSERT
  } state_t;

  state_t           r_state, w_state_next;
  logic [N_SRC-1:0] r_status, r_mask, r_prev, r_pend_d;
  logic             r_armed;
  logic [THR_W-1:0] r_thr, r_cnt, w_cnt_next, w_cnt_inc;
  logic [TMO_W-1:0] r_tmo, r_tmr, w_tmr_next;
  logic             r_int_out, r_rd_ack;
  logic [31:0]      r_rd_data, w_rd_mux;

  logic [N_SRC-1:0] w_set, w_w1c, w_force, w_status_next, w_pend;
  logic             w_wr_mask, w_wr_cfg, w_pend_any, w_new_evt, w_tmo_hit;
  logic             w_unused;

  assign w_unused = &{1'b0, wr_data};

  // Edge sources need one clock of valid history, so nothing fires on the first edge after reset.
  assign w_set = src_trig & ~(EDGE_SEL & (r_prev | {N_SRC{~r_armed}}));

  assign w_w1c         = (wr_stb && reg_addr == A_STATUS) ? wr_data[N_SRC-1:0] : '0;
  assign w_force       = (wr_stb && reg_addr == A_FORCE)  ? wr_data[N_SRC-1:0] : '0;
  assign w_wr_mask     = wr_stb && (reg_addr == A_MASK);
  assign w_wr_cfg      = wr_stb && (reg_addr == A_CFG);
  assign w_status_next = (r_status & ~w_w1c) | w_set | w_force;

  // A new masked event is a rising bit of (status & mask), which also covers unmasking a pending bit.
  assign w_pend     = r_status & r_mask;
  assign w_pend_any = |w_pend;
  assign w_new_evt  = |(w_pend & ~r_pend_d);
  assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + THR_ONE;
  assign w_tmo_hit  = (r_tmo != '0) && (r_tmr == r_tmo - TMR_ONE);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_tmr_next   = r_tmr;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        w_tmr_next = '0;
        if (w_new_evt) begin
          if (r_thr <= THR_ONE) begin
            w_state_next = S_ASSERT;
          end else begin
            w_state_next = S_COAL;
            w_cnt_next   = THR_ONE;
          end
        end
      end
      S_COAL: begin
        if (!w_pend_any) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_tmr_next   = '0;
        end else begin
          if (w_new_evt) w_cnt_next = w_cnt_inc;
          w_tmr_next = r_tmr + TMR_ONE;
          if ((w_cnt_next >= r_thr) || w_tmo_hit) w_state_next = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (!w_pend_any) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_tmr_next   = '0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_tmr_next   = '0;
      end
    endcase
  end

  always_comb begin
    w_rd_mux = '0;
    if (reg_addr == A_STATUS) begin
      w_rd_mux[N_SRC-1:0] = r_status;
    end else if (reg_addr == A_MASK) begin
      w_rd_mux[N_SRC-1:0] = r_mask;
    end else if (reg_addr == A_CFG) begin
      w_rd_mux[THR_W-1:0]  = r_thr;
      w_rd_mux[16 +: TMO_W] = r_tmo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_status  <= '0;
      r_mask    <= '1;
      r_prev    <= '0;
      r_pend_d  <= '0;
      r_armed   <= 1'b0;
      r_thr     <= THR_ONE;
      r_tmo     <= '0;
      r_cnt     <= '0;
      r_tmr     <= '0;
      r_int_out <= 1'b0;
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state_next;
      r_status  <= w_status_next;
      r_prev    <= src_trig;
      r_pend_d  <= w_pend;
      r_armed   <= 1'b1;
      r_cnt     <= w_cnt_next;
      r_tmr     <= w_tmr_next;
      r_int_out <= (w_state_next == S_ASSERT) || ext_int;
      r_rd_ack  <= rd_stb;
      r_rd_data <= rd_stb ? w_rd_mux : '0;
      if (w_wr_mask) r_mask <= wr_data[N_SRC-1:0];
      if (w_wr_cfg) begin
        r_thr <= wr_data[THR_W-1:0];
        r_tmo <= wr_data[16 +: TMO_W];
      end
    end
  end

  assign int_status = r_status;
  assign int_mask   = r_mask;
  assign int_out    = r_int_out;
  assign rd_ack     = r_rd_ack;
  assign rd_data    = r_rd_data;

endmodule

// File: tb/tb_cr_kme_int_aggr.sv
// Self-checking bench for cr_kme_int_aggr: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the aggregator.
module tb_cr_kme_int_aggr;

  localparam logic [10:0] BASE = 11'h37C;
  localparam logic [4:0]  EDGE = 5'b00001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  src_trig = '0;
  logic        ext_int = 1'b0;
  logic        wr_stb = 1'b0;
  logic        rd_stb = 1'b0;
  logic [10:0] reg_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        rd_ack;
  logic [4:0]  int_status;
  logic [4:0]  int_mask;
  logic        int_out;

  int n_total = 0;
  int n_bad = 0;

  cr_kme_int_aggr #(
    .N_SRC(5), .EDGE_SEL(EDGE), .THR_W(4), .TMO_W(16), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_trig(src_trig), .ext_int(ext_int),
    .wr_stb(wr_stb), .rd_stb(rd_stb), .reg_addr(reg_addr), .wr_data(wr_data),
    .rd_data(rd_data), .rd_ack(rd_ack), .int_status(int_status),
    .int_mask(int_mask), .int_out(int_out)
  );

  always #5 clk = ~clk;

  // Reference model: register file plus a three-phase coalescer (quiet, gathering, firing).
  logic [4:0]  m_status, m_mask, m_prev, m_seen;
  logic        m_armed, m_int_out, m_rd_ack;
  logic [31:0] m_rd_data;
  int          m_thr, m_tmo, m_phase, m_events, m_waited;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_status = '0; m_mask = '1; m_prev = '0; m_seen = '0; m_armed = 1'b0;
    m_int_out = 1'b0; m_rd_ack = 1'b0; m_rd_data = '0;
    m_thr = 1; m_tmo = 0; m_phase = 0; m_events = 0; m_waited = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [10:0] a);
    logic [31:0] v;
    v = '0;
    if (a == BASE) v = {27'd0, m_status};
    else if (a == BASE + 11'd2) v = {27'd0, m_mask};
    else if (a == BASE + 11'd3) v = (m_tmo << 16) | m_thr;
    return v;
  endfunction

  task automatic model_step();
    logic [4:0] pending, fresh, setv, clr, frc;
    int nxt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pending = m_status & m_mask;
    fresh   = pending & ~m_seen;
    nxt     = m_phase;
    if (m_phase == 0) begin
      if (fresh != 0) begin
        if (m_thr <= 1) nxt = 2;
        else begin nxt = 1; m_events = 1; m_waited = 0; end
      end
    end else if (m_phase == 1) begin
      if (pending == 0) nxt = 0;
      else begin
        if (fresh != 0 && m_events < 15) m_events++;
        if (m_events >= m_thr || (m_tmo != 0 && m_waited == m_tmo - 1)) nxt = 2;
        m_waited = (m_waited + 1) % 65536;
      end
    end else if (pending == 0) begin
      nxt = 0;
    end
    if (nxt == 0) begin m_events = 0; m_waited = 0; end
    m_phase   = nxt;
    m_int_out = (nxt == 2) || ext_int;
    m_rd_ack  = rd_stb;
    m_rd_data = rd_stb ? model_read(reg_addr) : 32'd0;
    for (int i = 0; i < 5; i++)
      setv[i] = EDGE[i] ? (src_trig[i] && !m_prev[i] && m_armed) : src_trig[i];
    clr = (wr_stb && reg_addr == BASE) ? wr_data[4:0] : 5'd0;
    frc = (wr_stb && reg_addr == BASE + 11'd1) ? wr_data[4:0] : 5'd0;
    m_status = (m_status & ~clr) | setv | frc;
    if (wr_stb && reg_addr == BASE + 11'd2) m_mask = wr_data[4:0];
    if (wr_stb && reg_addr == BASE + 11'd3) begin
      m_thr = int'(wr_data[3:0]);
      m_tmo = int'(wr_data[31:16]);
    end
    m_seen  = pending;
    m_prev  = src_trig;
    m_armed = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("status", {27'd0, int_status}, {27'd0, m_status});
    chk("mask", {27'd0, int_mask}, {27'd0, m_mask});
    chk("int_out", {31'd0, int_out}, {31'd0, m_int_out});
    chk("rd_ack", {31'd0, rd_ack}, {31'd0, m_rd_ack});
    chk("rd_data", rd_data, m_rd_data);
  endtask

  task automatic wr(input logic [10:0] a, input logic [31:0] d);
    wr_stb = 1'b1; reg_addr = a; wr_data = d;
    tick();
    wr_stb = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    model_reset();
    idle(2);
    chk("rst_status", {27'd0, int_status}, 32'd0);
    chk("rst_mask", {27'd0, int_mask}, 32'h1F);
    chk("rst_int_out", {31'd0, int_out}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // single level source, default config, then W1C
    src_trig = 5'b00100; tick();
    chk("r035_status", {27'd0, int_status}, 32'h4);
    chk("r035_out_lat", {31'd0, int_out}, 32'd0);
    src_trig = '0; tick();
    chk("r035_out", {31'd0, int_out}, 32'd1);
    wr(BASE, 32'h4);
    tick();
    chk("r035_out_clr", {31'd0, int_out}, 32'd0);
    idle(2);

    // set beats W1C, W1C alone, force, readback
    src_trig = 5'b00010; wr(BASE, 32'h2); src_trig = '0;
    chk("r038_setwins", {31'd0, int_status[1]}, 32'd1);
    wr(BASE, 32'h2);
    chk("r038_w1c", {31'd0, int_status[1]}, 32'd0);
    wr(BASE + 11'd1, 32'h10);
    chk("r038_force", {31'd0, int_status[4]}, 32'd1);
    rd_stb = 1'b1; reg_addr = BASE; tick(); rd_stb = 1'b0;
    chk("r038_rd_ack", {31'd0, rd_ack}, 32'd1);
    chk("r038_rd_data", rd_data, 32'h10);
    tick();
    chk("r038_rd_ack_off", {31'd0, rd_ack}, 32'd0);
    wr(BASE, 32'h1F); idle(3);

    // masked source, ext_int bypass, unmasking a pending bit
    wr(BASE + 11'd2, 32'h0);
    src_trig = 5'b01000; tick(); src_trig = '0;
    chk("r039_status", {27'd0, int_status}, 32'h8);
    idle(2);
    chk("r039_masked", {31'd0, int_out}, 32'd0);
    ext_int = 1'b1; tick(); ext_int = 1'b0;
    chk("r039_ext", {31'd0, int_out}, 32'd1);
    wr(BASE + 11'd2, 32'h8);
    tick();
    chk("r039_unmask", {31'd0, int_out}, 32'd1);
    wr(BASE, 32'h1F); wr(BASE + 11'd2, 32'h1F); idle(3);

    // count coalescing thr=3, no timeout; bit 0 is cleared so its second event is new
    wr(BASE + 11'd3, 32'h3);
    src_trig = 5'b00001; tick(); src_trig = '0;
    for (int i = 0; i < 5; i++) begin tick(); chk("r036_hold1", {31'd0, int_out}, 32'd0); end
    src_trig = 5'b00010; tick(); src_trig = '0;
    wr(BASE, 32'h1);
    for (int i = 0; i < 4; i++) begin tick(); chk("r036_hold2", {31'd0, int_out}, 32'd0); end
    src_trig = 5'b00001; tick(); src_trig = '0;
    chk("r036_third", {31'd0, int_out}, 32'd0);
    tick();
    chk("r036_fire", {31'd0, int_out}, 32'd1);
    wr(BASE, 32'h1F); idle(3);

    // timeout coalescing thr=8, tmo=10
    wr(BASE + 11'd3, (32'd10 << 16) | 32'd8);
    src_trig = 5'b10000; tick(); src_trig = '0;
    chk("r037_status", {31'd0, int_status[4]}, 32'd1);
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk("r037_tmo", {31'd0, int_out}, (k >= 11) ? 32'd1 : 32'd0);
    end
    wr(BASE, 32'h1F); idle(3);

    // edge source held high: one set only
    wr(BASE + 11'd3, 32'h1);
    src_trig = 5'b00001; tick();
    chk("r040_edge_set", {31'd0, int_status[0]}, 32'd1);
    wr(BASE, 32'h1);
    idle(18);
    chk("r040_edge_once", {31'd0, int_status[0]}, 32'd0);
    src_trig = '0; idle(3);

    // asynchronous reset while coalescing, edge source held through release
    wr(BASE + 11'd3, 32'h8);
    src_trig = 5'b00100; tick(); src_trig = '0;
    idle(2);
    rd_stb = 1'b1; reg_addr = BASE + 11'd3; tick(); rd_stb = 1'b0;
    chk("r040_pre_ack", {31'd0, rd_ack}, 32'd1);
    src_trig = 5'b00001;
    #2 rst_n = 1'b0;
    #1;
    chk("r040_arst_status", {27'd0, int_status}, 32'd0);
    chk("r040_arst_mask", {27'd0, int_mask}, 32'h1F);
    chk("r040_arst_out", {31'd0, int_out}, 32'd0);
    chk("r040_arst_ack", {31'd0, rd_ack}, 32'd0);
    chk("r040_arst_data", rd_data, 32'd0);
    model_reset();
    idle(2);
    rst_n = 1'b1;
    idle(4);
    chk("r034_hold_thru", {27'd0, int_status}, 32'd0);
    src_trig = '0; idle(2);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      logic [10:0] a;
      logic [31:0] d;
      for (int i = 0; i < 5; i++) src_trig[i] = ($urandom_range(0, 9) == 0);
      ext_int = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 5))
        0: a = BASE;
        1: a = BASE + 11'd1;
        2: a = BASE + 11'd2;
        3: a = BASE + 11'd3;
        4: a = 11'h100;
        default: a = BASE + 11'd4;
      endcase
      d = $urandom();
      if (a == BASE + 11'd3) d = ($urandom_range(0, 12) << 16) | $urandom_range(0, 5);
      if (a == BASE + 11'd1) d = d & ($urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0);
      wr_stb = ($urandom_range(0, 4) == 0);
      rd_stb = ($urandom_range(0, 3) == 0);
      reg_addr = a; wr_data = d;
      tick();
    end
    wr_stb = 1'b0; rd_stb = 1'b0; src_trig = '0; ext_int = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
